// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp32_pkg
// Purpose  : Shared constants, flag bit positions, FSM state type and a
//            field-packing helper for the iterative FP32 multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package fp32_pkg;

  localparam int          FP32_BIAS   = 127;
  localparam logic [31:0] FP32_QNAN   = 32'h7FC0_0000;
  localparam int          FP32_MANT_W = 24;

  // Bit positions inside the 4-bit flags vector
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [31:0] fp32_pack(input logic       s,
                                            input logic [7:0] e,
                                            input logic [22:0] f);
    return {s, e, f};
  endfunction

endpackage
`default_nettype wire

// File: rtl/Fp32Decoder.sv
`default_nettype none
// ============================================================================
// Module   : Fp32Decoder
// Purpose  : Splits a raw FP32 word into sign/exponent/fraction and
//            classifies it as zero, denormal, infinity or NaN.
// Ports    : x         in  32  raw FP32 operand
//            sign      out 1   sign bit
//            exp       out 8   biased exponent
//            frac      out 23  stored fraction (no implicit bit)
//            is_zero   out 1   +/-0
//            is_denorm out 1   exponent 0, fraction non-zero
//            is_inf    out 1   +/-infinity
//            is_nan    out 1   any NaN (quiet or signalling)
// Revision : 1.0 - initial release
// ============================================================================
module Fp32Decoder (
  input  logic [31:0] x,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [22:0] frac,
  output logic        is_zero,
  output logic        is_denorm,
  output logic        is_inf,
  output logic        is_nan
);

  logic exp_zero;
  logic exp_ones;
  logic frac_zero;

  assign sign      = x[31];
  assign exp       = x[30:23];
  assign frac      = x[22:0];

  assign exp_zero  = (x[30:23] == 8'h00);
  assign exp_ones  = (x[30:23] == 8'hFF);
  assign frac_zero = (x[22:0] == 23'd0);

  assign is_zero   = exp_zero &  frac_zero;
  assign is_denorm = exp_zero & ~frac_zero;
  assign is_inf    = exp_ones &  frac_zero;
  assign is_nan    = exp_ones & ~frac_zero;

endmodule
`default_nettype wire

// File: rtl/fp32_iter_mul.sv
`default_nettype none
// ============================================================================
// Module   : fp32_iter_mul
// Purpose  : Iterative FP32 multiplier. Radix-2 shift-add over 24 cycles,
//            flush-to-zero for denormal inputs and outputs, valid/ready on
//            both sides, one operation in flight at a time.
// Ports    : clk        in  1   rising-edge clock
//            rst_n      in  1   asynchronous active-low reset
//            in_valid   in  1   operand pair valid
//            in_ready   out 1   accept operands (registered, IDLE only)
//            a, b       in  32  raw FP32 operands
//            out_valid  out 1   result valid, held until accepted
//            out_ready  in  1   consumer accepts result
//            result     out 32  FP32 product
//            flags      out 4   {invalid, overflow, underflow, inexact}
// Config   : FP32_MUL_RNE_EN defined   -> round to nearest even
//            FP32_MUL_RNE_EN undefined -> round toward zero
// Revision : 1.0 - initial release
// ============================================================================
module fp32_iter_mul
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  localparam logic signed [9:0] BIAS_S = 10'(FP32_BIAS);

  // --------------------------------------------------------------------------
  // Operand decode
  // --------------------------------------------------------------------------
  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, a_den, a_inf, a_nan;
  logic        b_zero, b_den, b_inf, b_nan;

  Fp32Decoder u_dec_a (
    .x(a), .sign(sa), .exp(ea), .frac(fa),
    .is_zero(a_zero), .is_denorm(a_den), .is_inf(a_inf), .is_nan(a_nan)
  );

  Fp32Decoder u_dec_b (
    .x(b), .sign(sb), .exp(eb), .frac(fb),
    .is_zero(b_zero), .is_denorm(b_den), .is_inf(b_inf), .is_nan(b_nan)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e                   state_q,    state_d;
  logic                     in_ready_q, in_ready_d;
  logic [31:0]              result_q,   result_d;
  logic [3:0]               flags_q,    flags_d;
  logic                     sign_q,     sign_d;
  logic [7:0]               ea_q,       ea_d;
  logic [7:0]               eb_q,       eb_d;
  logic [FP32_MANT_W-1:0]   ma_q,       ma_d;
  logic [2*FP32_MANT_W-1:0] prod_q,     prod_d;
  logic [4:0]               cnt_q,      cnt_d;

  // --------------------------------------------------------------------------
  // Normalise / round path (consumed in ROUND)
  // --------------------------------------------------------------------------
  logic              norm;
  logic [22:0]       frac_t;
  logic              guard;
  logic              sticky;
  logic              round_inc;
  logic [23:0]       frac_r;
  logic signed [9:0] exp_pre;
  logic signed [9:0] exp_fin;

  always_comb begin
    norm   = prod_q[47];
    frac_t = prod_q[45:23];
    guard  = prod_q[22];
    sticky = |prod_q[21:0];
    if (norm) begin
      frac_t = prod_q[46:24];
      guard  = prod_q[23];
      sticky = |prod_q[22:0];
    end
`ifdef FP32_MUL_RNE_EN
    round_inc = guard & (sticky | frac_t[0]);
`else
    round_inc = 1'b0;
`endif
    // frac_r[23] is the carry out of the fraction; the fraction bits are
    // then all zero, which is exactly 1.0 at the next exponent.
    frac_r  = {1'b0, frac_t} + {23'd0, round_inc};
    exp_pre = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BIAS_S
              + $signed({9'd0, norm});
    exp_fin = exp_pre + $signed({9'd0, frac_r[23]});
  end

  // --------------------------------------------------------------------------
  // Shift-add step: the low half of prod holds the remaining multiplier
  // bits, the high half accumulates; each step shifts the pair right by one.
  // --------------------------------------------------------------------------
  logic [24:0] add_sum;
  assign add_sum = {1'b0, prod_q[47:24]} + (prod_q[0] ? {1'b0, ma_q} : 25'd0);

  // --------------------------------------------------------------------------
  // Next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    sign_d   = sign_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    ma_d     = ma_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d  = sa ^ sb;
          flags_d = 4'd0;
          state_d = ST_DONE;
          if (a_nan || b_nan) begin
            result_d = FP32_QNAN;
          end else if ((a_inf && (b_zero || b_den)) ||
                       (b_inf && (a_zero || a_den))) begin
            result_d               = FP32_QNAN;
            flags_d[FLAG_INVALID]  = 1'b1;
          end else if (a_inf || b_inf) begin
            result_d = fp32_pack(sa ^ sb, 8'hFF, 23'd0);
          end else if (a_zero || a_den || b_zero || b_den) begin
            result_d = fp32_pack(sa ^ sb, 8'h00, 23'd0);
          end else begin
            ea_d    = ea;
            eb_d    = eb;
            ma_d    = {1'b1, fa};
            prod_d  = {24'd0, 1'b1, fb};
            cnt_d   = 5'd0;
            state_d = ST_MUL;
          end
        end
      end

      ST_MUL: begin
        prod_d = {add_sum, prod_q[23:1]};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd23) begin
          state_d = ST_ROUND;
        end
      end

      ST_ROUND: begin
        flags_d = 4'd0;
        if (exp_fin >= 10'sd255) begin
          result_d                = fp32_pack(sign_q, 8'hFF, 23'd0);
          flags_d[FLAG_OVERFLOW]  = 1'b1;
          flags_d[FLAG_INEXACT]   = 1'b1;
        end else if (exp_fin <= 10'sd0) begin
          result_d                = fp32_pack(sign_q, 8'h00, 23'd0);
          flags_d[FLAG_UNDERFLOW] = 1'b1;
          flags_d[FLAG_INEXACT]   = 1'b1;
        end else begin
          result_d              = fp32_pack(sign_q, exp_fin[7:0], frac_r[22:0]);
          flags_d[FLAG_INEXACT] = guard | sticky;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered ready: high exactly while the FSM sits in IDLE.
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      result_q   <= 32'd0;
      flags_q    <= 4'd0;
      sign_q     <= 1'b0;
      ea_q       <= 8'd0;
      eb_q       <= 8'd0;
      ma_q       <= '0;
      prod_q     <= '0;
      cnt_q      <= 5'd0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      sign_q     <= sign_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      ma_q       <= ma_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_iter_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_iter_mul
// Purpose  : Directed self-checking bench for fp32_iter_mul.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_iter_mul;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int checks;
  int failures;

  fp32_iter_mul dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, transfers one pair, and returns the first sampled
  // result with its latency in edges after the transfer edge. Does not
  // perform the output handshake itself.
  task automatic issue(input logic [31:0] ai, input logic [31:0] bi,
                       output logic [31:0] r, output logic [3:0] f,
                       output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 60) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_wait_in_ready: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    a = ai;
    b = bi;
    tick();
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL issue_out_valid_timeout: out_valid=%0b required 1", out_valid);
    end
    r = result;
    f = flags;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %0b required 0", in_ready); end
    checks++;
    if (result !== 32'h0) begin failures++; $display("FAIL reset_result: got %08h required 00000000", result); end
    checks++;
    if (flags !== 4'h0) begin failures++; $display("FAIL reset_flags: got %04b required 0000", flags); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_before_edge: got %0b required 0", in_ready); end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_after_edge: got %0b required 1", in_ready); end
  endtask

  task automatic test_normal();
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    issue(32'h3FC00000, 32'h40000000, r, f, lat);
    tick();
    checks++;
    if (r !== 32'h40400000) begin failures++; $display("FAIL normal_result: got %08h required 40400000", r); end
    checks++;
    if (f !== 4'b0000) begin failures++; $display("FAIL normal_flags: got %04b required 0000", f); end
    checks++;
    if (lat != 25) begin failures++; $display("FAIL normal_latency: got %0d required 25", lat); end
    issue(32'hBFC00000, 32'h40000000, r, f, lat);
    tick();
    checks++;
    if (r !== 32'hC0400000) begin failures++; $display("FAIL normal_neg_result: got %08h required c0400000", r); end
  endtask

  task automatic test_specials();
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    issue(32'h7F800000, 32'h00000000, r, f, lat);
    tick();
    checks++;
    if (r !== 32'h7FC00000) begin failures++; $display("FAIL inf_zero_result: got %08h required 7fc00000", r); end
    checks++;
    if (f !== 4'b1000) begin failures++; $display("FAIL inf_zero_flags: got %04b required 1000", f); end
    checks++;
    if (lat != 0) begin failures++; $display("FAIL inf_zero_latency: got %0d required 0", lat); end

    issue(32'h7FC12345, 32'h3F800000, r, f, lat);
    tick();
    checks++;
    if (r !== 32'h7FC00000 || f !== 4'b0000) begin
      failures++; $display("FAIL nan_prop: got %08h/%04b required 7fc00000/0000", r, f);
    end

    issue(32'hFF800000, 32'h40000000, r, f, lat);
    tick();
    checks++;
    if (r !== 32'hFF800000 || f !== 4'b0000) begin
      failures++; $display("FAIL ninf_times_two: got %08h/%04b required ff800000/0000", r, f);
    end

    issue(32'h00000001, 32'h3F800000, r, f, lat);
    tick();
    checks++;
    if (r !== 32'h00000000 || f !== 4'b0000) begin
      failures++; $display("FAIL denorm_input: got %08h/%04b required 00000000/0000", r, f);
    end

    issue(32'h7F000000, 32'h7F000000, r, f, lat);
    tick();
    checks++;
    if (r !== 32'h7F800000 || f !== 4'b0101) begin
      failures++; $display("FAIL overflow: got %08h/%04b required 7f800000/0101", r, f);
    end

    issue(32'h00800000, 32'h00800000, r, f, lat);
    tick();
    checks++;
    if (r !== 32'h00000000 || f !== 4'b0011) begin
      failures++; $display("FAIL underflow: got %08h/%04b required 00000000/0011", r, f);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] r;
    logic [3:0]  f;
    logic [31:0] exp_r;
    int          lat;
`ifdef FP32_MUL_RNE_EN
    exp_r = 32'h40100002;
`else
    exp_r = 32'h40100001;
`endif
    issue(32'h3FC00001, 32'h3FC00001, r, f, lat);
    tick();
    checks++;
    if (r !== exp_r) begin failures++; $display("FAIL round_result: got %08h required %08h", r, exp_r); end
    checks++;
    if (f !== 4'b0001) begin failures++; $display("FAIL round_flags: got %04b required 0001", f); end
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    int          bad;
    out_ready = 1'b0;
    issue(32'h3FC00000, 32'h40000000, r, f, lat);
    in_valid = 1'b1;
    a = 32'h40400000;
    b = 32'h40400000;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid !== 1'b1 || result !== 32'h40400000 || flags !== 4'b0000 || in_ready !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold: got %0d unstable cycles required 0 (last %0b %08h %04b %0b)",
               bad, out_valid, result, flags, in_ready);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL backpressure_accept: out_valid=%0b required 0", out_valid); end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL backpressure_no_transfer: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    int          bad;
    in_valid = 1'b1;
    a = 32'h3FC00000;
    b = 32'h40000000;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL midreset_immediate: out_valid=%0b in_ready=%0b required 0/0", out_valid, in_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    bad = 0;
    #1;
    if (in_ready !== 1'b0) bad++;
    tick();
    checks++;
    if (in_ready !== 1'b1 || bad != 0) begin
      failures++; $display("FAIL midreset_in_ready: got %0b (early %0d) required 1", in_ready, bad);
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL midreset_out_valid_stays_low: got %0d high cycles required 0", bad); end
    issue(32'h3FC00000, 32'h40000000, r, f, lat);
    tick();
    checks++;
    if (r !== 32'h40400000) begin failures++; $display("FAIL midreset_next_op: got %08h required 40400000", r); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 32'h0;
    b         = 32'h0;
    #2;
    test_reset();
    test_normal();
    test_specials();
    test_rounding();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
